// File: rtl/pixel_readout_capture.sv
// Two-row frame capture from controller strobes into a single-frame output buffer, streamed one pixel per valid/ready beat.
// Define DARK_SUB_EN to emit each pixel as sample - DARK_LEVEL (saturating at 0) on the output path.
module pixel_readout_capture #(
   parameter int DATA_W     = 8,
   parameter int NUM_COLS   = 2,
   parameter int DARK_LEVEL = 16
) (
   input  logic                       Clk,
   input  logic                       Reset_n,
   input  logic                       NRE_1,
   input  logic                       NRE_2,
   input  logic                       ADC,
   input  logic                       Erase,
   input  logic [NUM_COLS*DATA_W-1:0] Adc_data,
   output logic [DATA_W-1:0]          Pix_data,
   output logic                       Pix_valid,
   input  logic                       Pix_ready,
   output logic                       Pix_sof,
   output logic                       Pix_eol,
   output logic                       Frame_done,
   output logic                       Overrun,
   output logic                       Busy
);

   localparam int ROW_W = NUM_COLS * DATA_W;
   localparam int BEATS = 2 * NUM_COLS;
   localparam int IDX_W = $clog2(BEATS);
   localparam logic [IDX_W-1:0] LP_LAST = IDX_W'(BEATS - 1);
   localparam logic [IDX_W-1:0] LP_EOL0 = IDX_W'(NUM_COLS - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ROW1_HELD,
      S_XFER
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [ROW_W-1:0]     r_row0;
   logic [ROW_W-1:0]     r_row1;
   logic [ROW_W-1:0]     r_obuf0;
   logic [ROW_W-1:0]     r_obuf1;
   logic                 r_ofull;
   logic [IDX_W-1:0]     r_idx;
   logic                 r_frame_done;
   logic                 r_overrun;

   logic                 w_row0_strobe;
   logic                 w_row1_strobe;
   logic                 w_cap_row0;
   logic                 w_cap_row1;
   logic                 w_load;
   logic                 w_drop;
   logic                 w_accept;
   logic                 w_last;
   logic [2*ROW_W-1:0]   w_frame;
   logic [DATA_W-1:0]    w_pix_raw;
   logic [DATA_W-1:0]    w_pix_out;

   // Both read enables low at once is an illegal strobe and matches neither decode.
   assign w_row0_strobe = ADC & ~NRE_1 &  NRE_2;
   assign w_row1_strobe = ADC &  NRE_1 & ~NRE_2;

   always_comb begin
      w_state_nxt = r_state;
      w_cap_row0  = 1'b0;
      w_cap_row1  = 1'b0;
      w_load      = 1'b0;
      w_drop      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_row0_strobe) begin
               w_cap_row0  = 1'b1;
               w_state_nxt = S_ROW1_HELD;
            end
         end
         S_ROW1_HELD: begin
            if (Erase) begin
               w_state_nxt = S_IDLE;
            end else if (w_row1_strobe) begin
               w_cap_row1  = 1'b1;
               w_state_nxt = S_XFER;
            end else if (w_row0_strobe) begin
               w_cap_row0  = 1'b1;
            end
         end
         S_XFER: begin
            w_state_nxt = S_IDLE;
            // Registered full flag: a buffer emptying on this same edge still counts as full.
            if (r_ofull) begin
               w_drop = 1'b1;
            end else begin
               w_load = 1'b1;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_state <= S_IDLE;
         r_row0  <= '0;
         r_row1  <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_cap_row0) begin
            r_row0 <= Adc_data;
         end
         if (w_cap_row1) begin
            r_row1 <= Adc_data;
         end
      end
   end

   assign w_accept = r_ofull & Pix_ready;
   assign w_last   = (r_idx == LP_LAST);

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_obuf0      <= '0;
         r_obuf1      <= '0;
         r_ofull      <= 1'b0;
         r_idx        <= '0;
         r_frame_done <= 1'b0;
         r_overrun    <= 1'b0;
      end else begin
         r_frame_done <= w_accept & w_last;
         if (w_drop) begin
            r_overrun <= 1'b1;
         end
         if (w_load) begin
            r_obuf0 <= r_row0;
            r_obuf1 <= r_row1;
            r_ofull <= 1'b1;
         end else if (w_accept && w_last) begin
            r_ofull <= 1'b0;
         end
         if (w_accept) begin
            r_idx <= w_last ? '0 : r_idx + 1'b1;
         end
      end
   end

   assign w_frame = {r_obuf1, r_obuf0};

   always_comb begin
      w_pix_raw = '0;
      for (int i = 0; i < BEATS; i++) begin
         if (r_idx == IDX_W'(i)) begin
            w_pix_raw = w_frame[i*DATA_W +: DATA_W];
         end
      end
   end

`ifdef DARK_SUB_EN
   localparam logic [DATA_W-1:0] LP_DARK = DATA_W'(DARK_LEVEL);
   assign w_pix_out = (w_pix_raw > LP_DARK) ? (w_pix_raw - LP_DARK) : '0;
`else
   assign w_pix_out = w_pix_raw;
`endif

   assign Pix_valid  = r_ofull;
   assign Pix_data   = r_ofull ? w_pix_out : '0;
   assign Pix_sof    = r_ofull & (r_idx == '0);
   assign Pix_eol    = r_ofull & ((r_idx == LP_EOL0) | w_last);
   assign Frame_done = r_frame_done;
   assign Overrun    = r_overrun;
   assign Busy       = (r_state != S_IDLE) | r_ofull;

endmodule
